hunter_mem_responder: RTL

- Memory-side responder for the Hunter_RV32 core's unified instruction/data port.
- Consumes the core's memory address, memory op and store data, and returns read data on the same interface.
- Holds 1 KB of word storage and serves halfword-aligned fetches that straddle two words.
- Contains a power-up sequencer: optional clear sweep, then a word-preload handshake for program images, during which the core is held.

---
 rtl/hunter_mem_pkg.sv | 28 ++
 rtl/hunter_mem_rd_align.sv | 18 +
 rtl/hunter_mem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hunter_mem_pkg.sv
// Shared encodings and helpers for the Hunter_RV32 memory responder.
package hunter_mem_pkg;

  localparam logic [1:0] MEMOP_RD = 2'b00;
  localparam logic [1:0] MEMOP_SW = 2'b01;
  localparam logic [1:0] MEMOP_SH = 2'b10;
  localparam logic [1:0] MEMOP_SB = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Lane enables for a core store; all-zero means the request is misaligned.
  function automatic logic [3:0] byte_en(input logic [1:0] op, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      MEMOP_SW: if (off == 2'd0) be = 4'b1111;
      MEMOP_SH: if (!off[0]) be = 4'b0011 << off;
      MEMOP_SB: be = 4'b0001 << off;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/hunter_mem_rd_align.sv
// Concatenates two adjacent words and shifts so the addressed byte lands in bits [7:0].
module hunter_mem_rd_align
  import hunter_mem_pkg::*;
(
  input  logic [31:0] hi_word,
  input  logic [31:0] lo_word,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [63:0] w_cat;
  logic [63:0] w_shift;

  assign w_cat   = {hi_word, lo_word};
  assign w_shift = w_cat >> {off, 3'b000};
  assign data    = w_shift[31:0];

endmodule

// File: rtl/hunter_mem_responder.sv
// Unified I/D memory responder with power-up sequencer (optional clear sweep, then preload).
// Optional clear sweep enabled by defining HUNTER_MEM_CLEAR_EN.
module hunter_mem_responder
  import hunter_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              core_hold,
  input  logic              boot_valid,
  output logic              boot_ready,
  input  logic [ADDR_W-3:0] boot_addr,
  input  logic [31:0]       boot_wdata,
  input  logic              boot_done,
  output logic              store_misalign
);

  localparam int unsigned WIDX_W = ADDR_W - 2;

  logic [31:0] r_mem [DEPTH_WORDS];
  state_t      r_state;
  logic        r_core_hold;
  logic        r_boot_ready;
  logic        r_misalign;
`ifdef HUNTER_MEM_CLEAR_EN
  logic [WIDX_W-1:0] r_clr_cnt;
`endif

  logic [WIDX_W-1:0] w_word;
  logic [WIDX_W-1:0] w_word_hi;
  logic [1:0]        w_off;
  logic [31:0]       w_aligned;
  logic [3:0]        w_store_be;
  logic              w_store_misaligned;
  logic [31:0]       w_store_data;
  logic [WIDX_W-1:0] w_widx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  assign w_word    = mem_addr[ADDR_W-1:2];
  assign w_word_hi = w_word + WIDX_W'(1);
  assign w_off     = mem_addr[1:0];

  hunter_mem_rd_align u_rd_align (
    .hi_word (r_mem[w_word_hi]),
    .lo_word (r_mem[w_word]),
    .off     (w_off),
    .data    (w_aligned)
  );

  assign mem_rdata      = (r_state == ST_RUN) ? w_aligned : 32'h0;
  assign core_hold      = r_core_hold;
  assign boot_ready     = r_boot_ready;
  assign store_misalign = r_misalign;

  assign w_store_be         = byte_en(mem_op, w_off);
  assign w_store_misaligned = (mem_op != MEMOP_RD) && (w_store_be == 4'b0000);

  always_comb begin
    case (mem_op)
      MEMOP_SW: w_store_data = mem_wdata;
      MEMOP_SH: w_store_data = {2{mem_wdata[15:0]}};
      default:  w_store_data = {4{mem_wdata[7:0]}};
    endcase
  end

  // Single storage write port shared by clear sweep, preload and core stores.
  always_comb begin
    w_widx  = w_word;
    w_be    = 4'b0000;
    w_wdata = w_store_data;
    case (r_state)
`ifdef HUNTER_MEM_CLEAR_EN
      ST_CLEAR: begin
        w_widx  = r_clr_cnt;
        w_be    = 4'b1111;
        w_wdata = 32'h0;
      end
`endif
      ST_BOOT: begin
        if (boot_valid && r_boot_ready) begin
          w_widx  = boot_addr;
          w_be    = 4'b1111;
          w_wdata = boot_wdata;
        end
      end
      ST_RUN:  w_be = w_store_be;
      default: w_be = 4'b0000;
    endcase
    if (rst) w_be = 4'b0000;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // Power-up sequencer; hold/ready are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef HUNTER_MEM_CLEAR_EN
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
`else
      r_state   <= ST_BOOT;
`endif
      r_core_hold  <= 1'b1;
      r_boot_ready <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      case (r_state)
`ifdef HUNTER_MEM_CLEAR_EN
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + WIDX_W'(1);
          if (r_clr_cnt == WIDX_W'(DEPTH_WORDS - 1)) begin
            r_state      <= ST_BOOT;
            r_boot_ready <= 1'b1;
          end
        end
`endif
        ST_BOOT: begin
          r_boot_ready <= 1'b1;
          if (boot_done) begin
            r_state      <= ST_RUN;
            r_core_hold  <= 1'b0;
            r_boot_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_store_misaligned) r_misalign <= 1'b1;
        end
        default: begin
          r_state      <= ST_BOOT;
          r_core_hold  <= 1'b1;
          r_boot_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
